// File: rtl/ifu_fetch_pkg.sv
// Core-wide fetch/control definitions shared by the fetch stage and the control generator.
package ifu_fetch_pkg;

    localparam logic [2:0]  BR_SEQ  = 3'd0;
    localparam logic [2:0]  BR_JAL  = 3'd1;
    localparam logic [2:0]  BR_JALR = 3'd2;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [63:0] DEF_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch_next_pc.sv
// Next-PC selection from the control generator's branch code, plus misalignment detection.
module ifu_next_pc
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    always_comb begin
        target = pc + XLEN'(4);
        case (branch)
            BR_JAL:  target = pc + imm;
            BR_JALR: target = alu_out & ~XLEN'(1);
            default: target = pc + XLEN'(4);  // BR_SEQ and reserved codes
        endcase
        misalign = target[1];
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, fetches over req/ready + rvalid, presents one instruction at a time.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    input  logic            imem_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_valid,
    input  logic            exec_done,
    input  logic [2:0]      branch,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_out,
    output logic            misalign
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] target;
    logic            target_mis;

    ifu_next_pc #(.XLEN(XLEN)) u_next_pc (
        .pc       (pc),
        .branch   (branch),
        .imm      (imm),
        .alu_out  (alu_out),
        .target   (target),
        .misalign (target_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= REQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            REQ:  if (imem_ready)  state_nxt = WAIT;
            WAIT: if (imem_rvalid) state_nxt = HOLD;
            HOLD: if (exec_done)   state_nxt = target_mis ? ERR : REQ;
            ERR:  state_nxt = ERR;
        endcase
    end

    // pc follows the target even on a misaligned jump so the trap address stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= RESET_PC;
            inst <= NOP_INST;
        end else begin
            if (state == WAIT && imem_rvalid) inst <= imem_rdata;
            if (state == HOLD && exec_done)   pc   <= target;
        end
    end

    // Request is gated by rst so it reads 0 while reset is held, although the state is already REQ.
    always_comb begin
        imem_req   = (state == REQ) && !rst;
        inst_valid = (state == HOLD);
        misalign   = (state == ERR);
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed, table-driven bench for ifu_fetch with hand-written reset/backpressure/error sequences.
module tb_ifu_fetch;

    localparam logic [63:0] RPC = 64'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_valid;
    logic        exec_done = 1'b0;
    logic [2:0]  branch = '0;
    logic [63:0] imm = '0;
    logic [63:0] alu_out = '0;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .inst_valid  (inst_valid),
        .exec_done   (exec_done),
        .branch      (branch),
        .imm         (imm),
        .alu_out     (alu_out),
        .misalign    (misalign)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        ed;
        logic [2:0]  br;
        logic [63:0] imm;
        logic [63:0] alu;
        logic        e_req;
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        logic        e_iv;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic ed, input logic [2:0] br, input logic [63:0] im,
                                input logic [63:0] alu, input logic e_req, input logic [63:0] e_pc,
                                input logic [31:0] e_inst, input logic e_iv, input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.ed = ed; v.br = br; v.imm = im; v.alu = alu;
        v.e_req = e_req; v.e_pc = e_pc; v.e_inst = e_inst; v.e_iv = e_iv; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_req, input logic [63:0] e_pc,
                           input logic [31:0] e_inst, input logic e_iv, input logic e_mis);
        chk({tag, ".req"},  64'(imem_req),   64'(e_req));
        chk({tag, ".addr"}, imem_addr,       e_pc);
        chk({tag, ".pc"},   pc,              e_pc);
        chk({tag, ".inst"}, 64'(inst),       64'(e_inst));
        chk({tag, ".iv"},   64'(inst_valid), 64'(e_iv));
        chk({tag, ".mis"},  64'(misalign),   64'(e_mis));
    endtask

    task automatic idle_inputs();
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; branch = '0; imm = '0; alu_out = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Walk: fetch, seq, spurious inputs, jal +12, jal -16, jalr, reserved code, misaligned jalr.
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, RPC,                  NOP,          0,0));
        tbl.push_back(mk(0,1,32'h0000_0297,0,0,64'h0,               64'h0,                  0, RPC,                  32'h0000_0297,1,0));
        tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,0,64'h0,               64'h0,                  0, RPC,                  32'h0000_0297,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,0,64'h0,               64'h0,                  1, 64'h8000_0004,        32'h0000_0297,0,0));
        tbl.push_back(mk(0,0,32'h0,        0,0,64'h0,               64'h0,                  1, 64'h8000_0004,        32'h0000_0297,0,0));
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, 64'h8000_0004,        32'h0000_0297,0,0));
        tbl.push_back(mk(0,0,32'h0,        1,1,64'h100,             64'h0,                  0, 64'h8000_0004,        32'h0000_0297,0,0));
        tbl.push_back(mk(0,1,32'h00C0_006F,0,0,64'h0,               64'h0,                  0, 64'h8000_0004,        32'h00C0_006F,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,1,64'hC,               64'h0,                  1, 64'h8000_0010,        32'h00C0_006F,0,0));
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, 64'h8000_0010,        32'h00C0_006F,0,0));
        tbl.push_back(mk(0,1,32'hFF1F_F06F,0,0,64'h0,               64'h0,                  0, 64'h8000_0010,        32'hFF1F_F06F,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,1,64'hFFFF_FFFF_FFFF_FFF0,64'h0,               1, 64'h8000_0000,        32'hFF1F_F06F,0,0));
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, 64'h8000_0000,        32'hFF1F_F06F,0,0));
        tbl.push_back(mk(0,1,32'h0000_0067,0,0,64'h0,               64'h0,                  0, 64'h8000_0000,        32'h0000_0067,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,2,64'h40,              64'h8000_0101,          1, 64'h8000_0100,        32'h0000_0067,0,0));
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, 64'h8000_0100,        32'h0000_0067,0,0));
        tbl.push_back(mk(0,1,32'h1111_1111,0,0,64'h0,               64'h0,                  0, 64'h8000_0100,        32'h1111_1111,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,5,64'h800,             64'h1234_5678,          1, 64'h8000_0104,        32'h1111_1111,0,0));
        tbl.push_back(mk(1,0,32'h0,        0,0,64'h0,               64'h0,                  0, 64'h8000_0104,        32'h1111_1111,0,0));
        tbl.push_back(mk(0,1,32'h2222_2222,0,0,64'h0,               64'h0,                  0, 64'h8000_0104,        32'h2222_2222,1,0));
        tbl.push_back(mk(0,0,32'h0,        1,2,64'h0,               64'h8000_0002,          0, 64'h8000_0002,        32'h2222_2222,0,1));
        tbl.push_back(mk(1,1,32'h3333_3333,1,0,64'h0,               64'h0,                  0, 64'h8000_0002,        32'h2222_2222,0,1));

        idle_inputs();
        tick();
        tick();
        chk_all("reset", 0, RPC, NOP, 0, 0);
        rst = 1'b0;
        #1;
        chk("release.req", 64'(imem_req), 64'd1);
        chk("release.addr", imem_addr, RPC);

        for (int i = 0; i < tbl.size(); i++) begin
            imem_ready  = tbl[i].rdy;
            imem_rvalid = tbl[i].rv;
            imem_rdata  = tbl[i].rdata;
            exec_done   = tbl[i].ed;
            branch      = tbl[i].br;
            imm         = tbl[i].imm;
            alu_out     = tbl[i].alu;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_pc, tbl[i].e_inst,
                    tbl[i].e_iv, tbl[i].e_mis);
        end

        // ERR is sticky: no requests regardless of what memory or execute do.
        for (int c = 0; c < 10; c++) begin
            imem_ready = 1'b1; imem_rvalid = 1'b1; exec_done = 1'b1; branch = 3'd0;
            tick();
            chk_all($sformatf("err%0d", c), 0, 64'h8000_0002, 32'h2222_2222, 0, 1);
        end
        idle_inputs();

        // Asynchronous reset out of ERR, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_err", 0, RPC, NOP, 0, 0);
        tick();
        rst = 1'b0;
        #1;

        // Backpressure: request and address hold until ready.
        for (int c = 0; c < 5; c++) begin
            imem_ready = 1'b0;
            tick();
            chk_all($sformatf("bp%0d", c), 1, RPC, NOP, 0, 0);
        end
        imem_ready = 1'b1;
        tick();
        chk_all("bp_acc", 0, RPC, NOP, 0, 0);
        imem_ready = 1'b0;

        // Reset while a response is outstanding, then a clean restart.
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_wait", 0, RPC, NOP, 0, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("restart.req", 64'(imem_req), 64'd1);
        imem_ready = 1'b1;
        tick();
        chk_all("restart_acc", 0, RPC, NOP, 0, 0);
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0297;
        tick();
        chk_all("restart_hold", 0, RPC, 32'h0000_0297, 1, 0);
        idle_inputs();
        tick();
        chk_all("restart_stable", 0, RPC, 32'h0000_0297, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
